// File: rtl/nvr_data_mem_responder.sv
// Strobe-protocol responder for the datapath data memory: working SRAM plus a
// same-size shadow image, with CE read/write, HS store and HR/POR recall.
module nvr_data_mem_responder #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] DIN,
  input  logic              CE,
  input  logic              WE,
  input  logic              HS,
  input  logic              HR,
  input  logic              POR,
  input  logic              err_clr,
  output logic [DATA_W-1:0] DOUT,
  output logic              RDY,
  output logic              busy_err
);
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {IDLE, READ, WRITE, STORE, RECALL} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] shd [DEPTH];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  req_t              req_q, req_d;
  logic [3:0]        strb_q, strb, rise;
  logic              rdy_d, err_d;
  logic [DATA_W-1:0] dout_d;

  logic              mem_wr, shd_wr;
  logic [ADDR_W-1:0] mem_wa, mem_ra;
  logic [DATA_W-1:0] mem_wd, mem_rd;

  // {POR, HR, HS, CE}; registered copies reset high so held levels don't fire
  assign strb = {POR, HR, HS, CE};
  assign rise = strb & ~strb_q;

  assign mem_ra = (state_q == STORE) ? idx_q : req_q.addr;
  assign mem_rd = mem[mem_ra];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    req_d   = req_q;
    rdy_d   = RDY;
    dout_d  = DOUT;
    mem_wr  = 1'b0;
    mem_wa  = req_q.addr;
    mem_wd  = req_q.data;
    shd_wr  = 1'b0;

    if (state_q != IDLE && |rise) err_d = 1'b1;
    else if (err_clr)             err_d = 1'b0;
    else                          err_d = busy_err;

    case (state_q)
      IDLE: begin
        if (rise[3] || rise[2]) begin
          state_d = RECALL;
          idx_d   = '0;
          rdy_d   = 1'b0;
        end else if (rise[1]) begin
          state_d = STORE;
          idx_d   = '0;
          rdy_d   = 1'b0;
        end else if (rise[0]) begin
          req_d = '{addr: A, data: DIN};
          rdy_d = 1'b0;
          if (WE) begin
            state_d = WRITE;
            cnt_d   = CNT_W'(WRITE_LAT - 1);
          end else begin
            state_d = READ;
            cnt_d   = CNT_W'(READ_LAT - 1);
          end
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          dout_d  = mem_rd;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WRITE: begin
        if (cnt_q == '0) begin
          mem_wr  = 1'b1;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STORE: begin
        shd_wr = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == '1) begin
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RECALL: begin
        mem_wr = 1'b1;
        mem_wa = idx_q;
        mem_wd = shd[idx_q];
        idx_d  = idx_q + 1'b1;
        if (idx_q == '1) begin
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      req_q    <= '0;
      strb_q   <= '1;
      RDY      <= 1'b1;
      DOUT     <= '0;
      busy_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      req_q    <= req_d;
      strb_q   <= strb;
      RDY      <= rdy_d;
      DOUT     <= dout_d;
      busy_err <= err_d;
    end
  end

  // Array contents survive reset; only the FSM is cleared, so an aborted write never lands
  always_ff @(posedge clk) begin
    if (mem_wr) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (shd_wr) shd[idx_q] <= mem_rd;
  end

endmodule

// File: tb/tb_nvr_data_mem_responder.sv
// Randomized + directed bench: transaction-level latency model compared every cycle.
module tb_nvr_data_mem_responder;
  localparam int ADDR_W = 7, DATA_W = 32, READ_LAT = 2, WRITE_LAT = 4;
  localparam int DEPTH = 1 << ADDR_W;

  logic clk, reset, CE, WE, HS, HR, POR, err_clr;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] DIN, DOUT;
  logic RDY, busy_err;

  int checks = 0;
  int errors = 0;

  nvr_data_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT),
                           .WRITE_LAT(WRITE_LAT)) dut (
    .clk(clk), .reset(reset), .A(A), .DIN(DIN), .CE(CE), .WE(WE), .HS(HS),
    .HR(HR), .POR(POR), .err_clr(err_clr), .DOUT(DOUT), .RDY(RDY), .busy_err(busy_err));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // model: an accepted op occupies a fixed number of cycles, effect lands on the last
  localparam int OP_RD = 0, OP_WR = 1, OP_ST = 2, OP_RC = 3;
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_shd [DEPTH];
  logic [DATA_W-1:0] m_dout, m_d;
  logic [ADDR_W-1:0] m_a;
  logic m_rdy, m_err, p_ce, p_hs, p_hr, p_por;
  int m_busy, m_op;
  logic e_ce, e_hs, e_hr, e_por, e_any;

  assign e_ce  = CE & ~p_ce;
  assign e_hs  = HS & ~p_hs;
  assign e_hr  = HR & ~p_hr;
  assign e_por = POR & ~p_por;
  assign e_any = e_ce | e_hs | e_hr | e_por;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rdy <= 1; m_dout <= 0; m_err <= 0; m_busy <= 0; m_op <= OP_RD;
      p_ce <= 1; p_hs <= 1; p_hr <= 1; p_por <= 1;
    end else begin
      p_ce <= CE; p_hs <= HS; p_hr <= HR; p_por <= POR;
      if (m_busy != 0) begin
        if (e_any) m_err <= 1;
        else if (err_clr) m_err <= 0;
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_rdy <= 1;
          case (m_op)
            OP_RD: m_dout <= m_mem[m_a];
            OP_WR: m_mem[m_a] <= m_d;
            OP_ST: for (int i = 0; i < DEPTH; i++) m_shd[i] <= m_mem[i];
            default: for (int i = 0; i < DEPTH; i++) m_mem[i] <= m_shd[i];
          endcase
        end
      end else begin
        if (err_clr) m_err <= 0;
        if (e_por || e_hr) begin
          m_op <= OP_RC; m_busy <= DEPTH; m_rdy <= 0;
        end else if (e_hs) begin
          m_op <= OP_ST; m_busy <= DEPTH; m_rdy <= 0;
        end else if (e_ce) begin
          m_a <= A; m_d <= DIN; m_rdy <= 0;
          m_op <= WE ? OP_WR : OP_RD;
          m_busy <= WE ? WRITE_LAT : READ_LAT;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("RDY", 32'(RDY), 32'(m_rdy));
      chk("DOUT", DOUT, m_dout);
      chk("busy_err", 32'(busy_err), 32'(m_err));
    end
  end

  // called at a negedge; returns the number of cycles RDY stayed low
  task automatic go(input logic ce, we, hs, hr, por, input logic [ADDR_W-1:0] a,
                    input logic [DATA_W-1:0] d, output int low);
    CE = ce; WE = we; HS = hs; HR = hr; POR = por; A = a; DIN = d;
    @(negedge clk);
    CE = 0; HS = 0; HR = 0; POR = 0;
    low = 0;
    while (RDY == 0 && low < 1000) begin
      low++;
      @(negedge clk);
    end
    if (low >= 1000) begin
      checks++; errors++;
      $display("FAIL rdy_timeout: RDY low for %0d cycles, required to rise", low);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    reset = 0; CE = 1; WE = 0; HS = 0; HR = 0; POR = 0; err_clr = 0; A = 0; DIN = 0;
    @(negedge clk); @(negedge clk);
    chk("reset_rdy", 32'(RDY), 1);
    chk("reset_dout", DOUT, 0);
    chk("reset_err", 32'(busy_err), 0);
    reset = 1;
    repeat (3) @(negedge clk);
    chk("ce_held_no_op", 32'(RDY), 1);
    CE = 0;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) go(1, 1, 0, 0, 0, 7'(i), $urandom, low);
    go(0, 0, 1, 0, 0, 0, 0, low);

    go(1, 1, 0, 0, 0, 7'd5, 32'hDEADBEEF, low);
    chk("write_lat", low, 4);
    go(1, 0, 0, 0, 0, 7'd5, 0, low);
    chk("read_lat", low, 2);
    chk("read_data", DOUT, 32'hDEADBEEF);

    go(1, 1, 0, 0, 0, 7'd0, 32'h11, low);
    go(1, 1, 0, 0, 0, 7'd127, 32'h22, low);
    go(0, 0, 1, 0, 0, 0, 0, low);
    chk("store_lat", low, 128);
    go(1, 1, 0, 0, 0, 7'd0, 32'h99, low);
    go(0, 0, 0, 1, 0, 0, 0, low);
    chk("recall_lat", low, 128);
    go(1, 0, 0, 0, 0, 7'd0, 0, low);
    chk("recall_addr0", DOUT, 32'h11);
    go(1, 0, 0, 0, 0, 7'd127, 0, low);
    chk("recall_addr127", DOUT, 32'h22);

    // second CE edge lands on the completing edge of the first read
    CE = 1; WE = 0; A = 7'd5;
    @(negedge clk); CE = 0;
    @(negedge clk); CE = 1; A = 7'd0;
    @(negedge clk); CE = 0;
    chk("collide_rdy", 32'(RDY), 1);
    chk("collide_dout", DOUT, 32'hDEADBEEF);
    chk("collide_err", 32'(busy_err), 1);
    @(negedge clk);
    chk("collide_dropped", 32'(RDY), 1);
    err_clr = 1;
    @(negedge clk); err_clr = 0;
    chk("err_clr", 32'(busy_err), 0);

    go(1, 1, 0, 0, 0, 7'd9, 32'h5A5A, low);
    go(1, 1, 1, 0, 0, 7'd9, 32'hFFFF0000, low);
    chk("prio_store_lat", low, 128);
    chk("prio_no_err", 32'(busy_err), 0);
    go(1, 0, 0, 0, 0, 7'd9, 0, low);
    chk("prio_no_write", DOUT, 32'h5A5A);

    go(1, 1, 0, 0, 0, 7'd3, 32'h12345678, low);
    CE = 1; WE = 1; A = 7'd3; DIN = 32'hAAAA5555;
    @(negedge clk); CE = 0;
    @(negedge clk); @(negedge clk);
    reset = 0;
    #1;
    chk("midreset_rdy", 32'(RDY), 1);
    @(negedge clk); @(negedge clk);
    reset = 1;
    @(negedge clk);
    go(1, 0, 0, 0, 0, 7'd3, 0, low);
    chk("midreset_no_commit", DOUT, 32'h12345678);

    for (int c = 0; c < 4000; c++) begin
      CE = ($urandom_range(0, 2) == 0);
      WE = 1'($urandom_range(0, 1));
      A = 7'($urandom);
      DIN = $urandom;
      HS = ($urandom_range(0, 299) == 0);
      HR = ($urandom_range(0, 299) == 0);
      POR = ($urandom_range(0, 299) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    CE = 0; HS = 0; HR = 0; POR = 0; err_clr = 0;
    low = 0;
    while (RDY == 0 && low < 300) begin
      low++;
      @(negedge clk);
    end
    chk("final_idle", 32'(RDY), 1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
